// File: rtl/zle_arb_pkg.sv
// zle_arb_pkg
//   Shared definitions for the ZLE encoder arbiter: number of requester
//   streams, channel-index width and the arbiter state encoding.
package zle_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RSVD  = 2'd3
  } state_t;

endpackage

// File: rtl/zle_arb_pick.sv
// rr_pick4
//   Combinational 4-way round-robin pick. Searches ptr+1, ptr+2, ptr+3, ptr
//   (modulo 4) and returns the first requesting channel.
//   Ports:
//     req     [3:0]  request vector
//     ptr     [1:0]  last served channel (lowest priority this round)
//     gnt_ch  [1:0]  selected channel; only meaningful when any_req=1
//     any_req        at least one request present
module rr_pick4
  import zle_arb_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_ch,
  output logic            any_req
);

  // Walk the search order backwards so the earliest candidate overwrites
  // any later one and ends up as the result.
  always_comb begin
    gnt_ch  = ptr;
    any_req = |req;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr + CH_W'(i)]) begin
        gnt_ch = ptr + CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/zle_arb.sv
// zle_arb
//   Round-robin arbiter that hands a single shared ZLE encoder to one of four
//   token streams for a whole block at a time. A block ends with a token
//   carrying in_last; the arbiter then waits for the encoder to report idle
//   before re-arbitrating, so encoder run state never mixes two streams.
//   Ports:
//     clock, reset        clock (rising edge), async active-low reset
//     in_v/in_b/in_d      per-stream token valid / stall / data (stream k at [k*W +: W])
//     in_last             per-stream end-of-block marker
//     ch_en               per-stream enable mask, consulted only when selecting
//     e_v/e_b/e_d         token stream to the encoder
//     e_idle              encoder back in its start state with nothing pending
//     grant_ch            current or most recent granted channel
//     stateo              arbiter state
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no owner; pick next requester, grant takes effect next cycle
//   GRANT | grant_ch owns the encoder; tokens pass combinationally
//   DRAIN | block finished; all streams stalled until encoder is idle
//   RSVD  | unused code, recovers to IDLE
module zle_arb
  import zle_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int N = NUM_CH   // structure is built for exactly four streams
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     in_v,
  output logic [N-1:0]     in_b,
  input  logic [N*W-1:0]   in_d,
  input  logic [N-1:0]     in_last,
  input  logic [N-1:0]     ch_en,
  output logic             e_v,
  input  logic             e_b,
  output logic [W-1:0]     e_d,
  input  logic             e_idle,
  output logic [CH_W-1:0]  grant_ch,
  output logic [1:0]       stateo
);

  state_t          state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] grant_q, grant_d;

  logic [N-1:0]    req;
  logic [CH_W-1:0] pick_ch;
  logic            any_req;
  logic [W-1:0]    d_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign d_arr[k] = in_d[k*W +: W];
  end

  assign req = in_v & ch_en;

  rr_pick4 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_ch  (pick_ch),
    .any_req (any_req)
  );

  // ptr resets to 3 so channel 0 is searched first after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(3);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    e_v     = 1'b0;
    e_d     = '0;
    in_b    = '1;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick_ch;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        e_v           = in_v[grant_q];
        e_d           = d_arr[grant_q];
        in_b[grant_q] = e_b;
        if (in_v[grant_q] && !e_b && in_last[grant_q]) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // The round-robin pointer only advances once the block is fully
        // flushed out of the encoder.
        if (e_idle) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grant_ch = grant_q;
  assign stateo   = state_q;

endmodule

// File: tb/tb_zle_arb.sv
module tb_zle_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic [N-1:0]   in_v;
  logic [N-1:0]   in_b;
  logic [N*W-1:0] in_d;
  logic [N-1:0]   in_last;
  logic [N-1:0]   ch_en;
  logic           e_v;
  logic           e_b;
  logic [W-1:0]   e_d;
  logic           e_idle;
  logic [1:0]     grant_ch;
  logic [1:0]     stateo;

  int tests;
  int fails;
  logic [W-1:0] sb [$];

  zle_arb #(.W(W), .N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_v     (in_v),
    .in_b     (in_b),
    .in_d     (in_d),
    .in_last  (in_last),
    .ch_en    (ch_en),
    .e_v      (e_v),
    .e_b      (e_b),
    .e_d      (e_d),
    .e_idle   (e_idle),
    .grant_ch (grant_ch),
    .stateo   (stateo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: a transfer that will happen on the next rising edge is
  // visible at the falling edge; compare it against the oldest expected token.
  always @(negedge clock) begin
    if (reset === 1'b1 && e_v === 1'b1 && e_b === 1'b0) begin
      logic [W-1:0] exp_tok;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got token %0h, required none pending", e_d);
      end else begin
        exp_tok = sb.pop_front();
        if (e_d !== exp_tok) begin
          fails++;
          $display("FAIL sb_token: got %0h, required %0h", e_d, exp_tok);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_d(input int k, input logic [W-1:0] val);
    in_d[k*W +: W] = val;
  endtask

  // Independent reference for round-robin selection.
  function automatic int model_pick(input logic [3:0] req, input int ptr);
    int r;
    r = -1;
    for (int i = 1; i <= 4; i++) begin
      if (r < 0 && req[(ptr + i) % 4]) r = (ptr + i) % 4;
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_v = '0; in_d = '0; in_last = '0; ch_en = '0;
    e_b = 1'b0; e_idle = 1'b0;
    tick(); tick();
    tests++;
    if (stateo !== 2'd0 || in_b !== 4'b1111 || e_v !== 1'b0 || grant_ch !== 2'd0) begin
      fails++;
      $display("FAIL reset_vals: got st=%0d in_b=%b e_v=%b g=%0d, required 0 1111 0 0",
               stateo, in_b, e_v, grant_ch);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_first_grant();
    ch_en = 4'b1111; in_v = 4'b0101; in_last = 4'b0101;
    set_d(0, 8'h11); set_d(2, 8'h22);
    #1;
    tests++;
    if (stateo !== 2'd0 || e_v !== 1'b0) begin
      fails++;
      $display("FAIL s1_idle_nopass: got st=%0d e_v=%b, required 0 0", stateo, e_v);
    end
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd0 || in_b !== 4'b1110) begin
      fails++;
      $display("FAIL s1_grant0: got st=%0d g=%0d in_b=%b, required 1 0 1110",
               stateo, grant_ch, in_b);
    end
    sb.push_back(8'h11);
    tick();
    in_v = 4'b0100;
    tests++;
    if (stateo !== 2'd2 || e_v !== 1'b0 || in_b !== 4'b1111) begin
      fails++;
      $display("FAIL s1_drain: got st=%0d e_v=%b in_b=%b, required 2 0 1111",
               stateo, e_v, in_b);
    end
    e_idle = 1'b1;
    tick();
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd2) begin
      fails++;
      $display("FAIL s1_grant2: got st=%0d g=%0d, required 1 2", stateo, grant_ch);
    end
    sb.push_back(8'h22);
    tick();
    in_v = '0;
    tick();
    e_idle = 1'b0;
  endtask

  task automatic test_stall_block();
    logic [W-1:0] toks [4];
    toks[0] = 8'd5; toks[1] = 8'd0; toks[2] = 8'd0; toks[3] = 8'd7;
    in_v = 4'b0010; in_last = '0; e_b = 1'b1;
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd1) begin
      fails++;
      $display("FAIL s2_grant1: got st=%0d g=%0d, required 1 1", stateo, grant_ch);
    end
    for (int i = 0; i < 4; i++) begin
      set_d(1, toks[i]);
      in_last = (i == 3) ? 4'b0010 : 4'b0000;
      e_b = 1'b1;
      #1;
      tests++;
      if (e_v !== 1'b1 || e_d !== toks[i] || in_b !== 4'b1111) begin
        fails++;
        $display("FAIL s2_stalled: tok %0d got e_v=%b e_d=%0h in_b=%b, required 1 %0h 1111",
                 i, e_v, e_d, in_b, toks[i]);
      end
      sb.push_back(toks[i]);
      tick();
      e_b = 1'b0;
      #1;
      tests++;
      if (in_b !== 4'b1101) begin
        fails++;
        $display("FAIL s2_open: tok %0d got in_b=%b, required 1101", i, in_b);
      end
      tick();
    end
    tests++;
    if (stateo !== 2'd2) begin
      fails++;
      $display("FAIL s2_drain: got st=%0d, required 2", stateo);
    end
    in_v = '0; in_last = '0; e_idle = 1'b1;
    tick();
    e_idle = 1'b0;
  endtask

  task automatic test_fairness();
    int mptr;
    int exp_ch;
    int n;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mptr = 3;
    for (int k = 0; k < 4; k++) set_d(k, 8'h30 + 8'(k));
    in_v = 4'b1111; in_last = 4'b1111; ch_en = 4'b1111; e_b = 1'b0; e_idle = 1'b1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (stateo !== 2'd1 && n < 5) begin
        tick();
        n++;
      end
      exp_ch = model_pick(in_v & ch_en, mptr);
      tests++;
      if (stateo !== 2'd1 || grant_ch !== 2'(exp_ch)) begin
        fails++;
        $display("FAIL s3_order: grant %0d got st=%0d ch=%0d, required 1 %0d",
                 g, stateo, grant_ch, exp_ch);
      end
      sb.push_back(8'h30 + 8'(exp_ch));
      tick();
      tests++;
      if (stateo !== 2'd2) begin
        fails++;
        $display("FAIL s3_drain_with_idle: grant %0d got st=%0d, required 2", g, stateo);
      end
      mptr = exp_ch;
    end
    in_v = '0; in_last = '0;
    tick();
    e_idle = 1'b0;
  endtask

  task automatic test_mask();
    ch_en = 4'b1011; in_v = 4'b0100; in_last = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (stateo !== 2'd0 || e_v !== 1'b0) begin
        fails++;
        $display("FAIL s4_masked: cycle %0d got st=%0d e_v=%b, required 0 0", i, stateo, e_v);
      end
    end
    ch_en = 4'b1111;
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd2) begin
      fails++;
      $display("FAIL s4_grant2: got st=%0d g=%0d, required 1 2", stateo, grant_ch);
    end
    set_d(2, 8'hA1);
    sb.push_back(8'hA1);
    ch_en = 4'b1011;
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd2 || in_b !== 4'b1011) begin
      fails++;
      $display("FAIL s4_no_abort: got st=%0d g=%0d in_b=%b, required 1 2 1011",
               stateo, grant_ch, in_b);
    end
    set_d(2, 8'hA2);
    in_last = 4'b0100;
    sb.push_back(8'hA2);
    tick();
    tests++;
    if (stateo !== 2'd2) begin
      fails++;
      $display("FAIL s4_complete: got st=%0d, required 2", stateo);
    end
    in_v = '0; in_last = '0; e_idle = 1'b1;
    tick();
    e_idle = 1'b0; ch_en = 4'b1111;
  endtask

  task automatic test_drain_hold();
    in_v = 4'b0001; in_last = 4'b0001; set_d(0, 8'h55);
    tick();
    sb.push_back(8'h55);
    tick();
    in_v = '0; in_last = '0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (stateo !== 2'd2 || e_v !== 1'b0 || in_b !== 4'b1111) begin
        fails++;
        $display("FAIL s5_hold: cycle %0d got st=%0d e_v=%b in_b=%b, required 2 0 1111",
                 i, stateo, e_v, in_b);
      end
      tick();
    end
    e_idle = 1'b1;
    tick();
    tests++;
    if (stateo !== 2'd0) begin
      fails++;
      $display("FAIL s5_release: got st=%0d, required 0", stateo);
    end
    e_idle = 1'b0;
  endtask

  task automatic test_reset_mid_block();
    in_v = 4'b1000; in_last = '0; set_d(3, 8'h61);
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd3) begin
      fails++;
      $display("FAIL s6_grant3: got st=%0d g=%0d, required 1 3", stateo, grant_ch);
    end
    sb.push_back(8'h61);
    tick();
    set_d(3, 8'h62);
    reset = 1'b0;
    #1;
    tests++;
    if (stateo !== 2'd0 || in_b !== 4'b1111 || e_v !== 1'b0 || grant_ch !== 2'd0) begin
      fails++;
      $display("FAIL s6_async_reset: got st=%0d in_b=%b e_v=%b g=%0d, required 0 1111 0 0",
               stateo, in_b, e_v, grant_ch);
    end
    tick();
    reset = 1'b1;
    in_v = 4'b1001; in_last = 4'b0001; set_d(0, 8'h70);
    tick();
    tests++;
    if (stateo !== 2'd1 || grant_ch !== 2'd0) begin
      fails++;
      $display("FAIL s6_after_reset: got st=%0d g=%0d, required 1 0", stateo, grant_ch);
    end
    sb.push_back(8'h70);
    tick();
    in_v = '0; in_last = '0; e_idle = 1'b1;
    tick();
    e_idle = 1'b0;
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d tokens pending, required 0", sb.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_grant();
    test_stall_block();
    test_fairness();
    test_mask();
    test_drain_hold();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zle_arb.md
ZLE_ARB -- requirements
Module: zle_arb

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the token data width of every stream.
REQ-002 The block SHALL have parameter N, fixed at 4, meaning the number of requester streams; the channel index is 2 bits.
REQ-003 clock  input  1  system clock, all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_v  input  N  per-stream token valid.
REQ-006 in_b  output  N  per-stream back-pressure; 1 = stall.
REQ-007 in_d  input  N*W  per-stream token data; stream k occupies bits [k*W +: W].
REQ-008 in_last  input  N  per-stream end-of-block marker, qualified by in_v.
REQ-009 ch_en  input  N  per-stream enable mask; 0 = never granted.
REQ-010 e_v  output  1  token valid to the shared ZLE encoder.
REQ-011 e_b  input  1  encoder back-pressure.
REQ-012 e_d  output  W  token data to the encoder.
REQ-013 e_idle  input  1  encoder in start state with no pending output.
REQ-014 grant_ch  output  2  currently or last granted channel.
REQ-015 stateo  output  2  arbiter state for the datapath and debug.

Function
REQ-016 A transfer SHALL occur on stream k in any cycle where in_v[k]=1 and in_b[k]=0; the encoder side transfers when e_v=1 and e_b=0.
REQ-017 States SHALL be IDLE=0, GRANT=1, DRAIN=2; code 3 SHALL transition to IDLE.
REQ-018 IDLE: if (in_v & ch_en) != 0, the block SHALL select the first set bit searching ptr+1, ptr+2, ... modulo 4, load grant_ch, and enter GRANT next cycle; otherwise it stays in IDLE.
REQ-019 Arbitration latency SHALL be exactly one cycle, IDLE to GRANT; no token SHALL pass in IDLE.
REQ-020 GRANT: the pass-through SHALL be combinational: e_v=in_v[grant_ch], e_d=in_d[grant_ch], in_b[grant_ch]=e_b; all other in_b SHALL be 1.
REQ-021 GRANT: a transfer with in_last[grant_ch]=1 SHALL move the block to DRAIN next cycle; that last token passes normally.
REQ-022 DRAIN: e_v SHALL be 0 and all in_b SHALL be 1.
REQ-023 DRAIN: when e_idle=1 the block SHALL set ptr=grant_ch and enter IDLE next cycle.
REQ-024 Clearing ch_en[grant_ch] during GRANT or DRAIN SHALL NOT abort the grant; the mask affects only selection in IDLE.
REQ-025 A grant SHALL never be split mid-block; the encoder run state belongs to exactly one stream at a time.
REQ-026 Simultaneous in_last transfer and e_idle=1 in GRANT SHALL still pass through DRAIN; e_idle is sampled only in DRAIN.
REQ-027 grant_ch SHALL hold its value in DRAIN and IDLE until the next selection.
REQ-028 stateo SHALL equal the current state register.

Reset
REQ-029 While reset=0: state=IDLE, ptr=3 (channel 0 has first priority), grant_ch=0, in_b=4'b1111, e_v=0, stateo=0.
REQ-030 Reset asserted mid-GRANT or mid-DRAIN SHALL return the block to the REQ-029 values immediately; no partial token is retained.

Structure
REQ-031 Package zle_arb_pkg SHALL hold the state encodings, N, and the channel-index width.
REQ-032 The round-robin selection SHALL be a combinational sub-module rr_pick4, with inputs req[3:0] and ptr[1:0] and outputs gnt_ch[1:0] and any_req.
REQ-033 Datapath muxing and the FSM SHALL reside in zle_arb; the total SHALL be 120-400 RTL lines.

Verification
REQ-034 Scenario 1: after reset, in_v=4'b0101 with ch_en=4'b1111 -> grant_ch=0 and GRANT one cycle later; after ch0 last and e_idle=1 -> the next grant is ch2.
REQ-035 Scenario 2: ch1 block of tokens 5,0,0,7 (last on 7) with e_b toggling 1,0 -> e_d sequence 5,0,0,7 in order, each taken only when e_b=0, in_b[0,2,3]=1 throughout.
REQ-036 Scenario 3: all four streams valid continuously -> grant order 0,1,2,3,0; no channel served twice before the others.
REQ-037 Scenario 4: ch_en=4'b1011 with in_v=4'b0100 -> stays in IDLE; set ch_en[2]=1 -> grant_ch=2; clear ch_en[2] mid-block -> the block completes.
REQ-038 Scenario 5: in DRAIN, hold e_idle=0 for 10 cycles -> e_v=0 and in_b=4'b1111 for all 10 cycles; e_idle=1 -> IDLE next cycle.
REQ-039 Scenario 6: assert reset during GRANT with ch3 mid-block -> outputs match REQ-029 in the same cycle, and after release the next grant is ch0.
